// File: rtl/darkriscv_wb_pkg.sv
// darkriscv_wb_pkg: shared FSM states, access-size codes and defaults for the Wishbone adapter
package darkriscv_wb_pkg;
    typedef enum logic [1:0] {IDLE, DACCESS, IFETCH, GAP} state_t;
    localparam logic [2:0] DLEN_B = 3'd1;
    localparam logic [2:0] DLEN_H = 3'd2;
    localparam logic [2:0] DLEN_W = 3'd4;
    localparam int TIMEOUT_DEFAULT = 255;
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/darkriscv_wb_if.sv
// darkriscv_wb_if: classic Wishbone single-master bus bundle
interface darkriscv_wb_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [3:0]  sel_o;
    logic [31:0] data_i;
    logic        ack_i;
    modport master(output cyc_o, stb_o, we_o, addr_o, data_o, sel_o, input data_i, ack_i);
    modport slave(input cyc_o, stb_o, we_o, addr_o, data_o, sel_o, output data_i, ack_i);
endinterface

// File: rtl/darkriscv_wb_sel.sv
// darkriscv_wb_sel: byte-lane select and alignment check for a core data access
module darkriscv_wb_sel
    import darkriscv_wb_pkg::*;
(
    input  logic [1:0] addr_i,
    input  logic [2:0] dlen_i,
    output logic [3:0] sel_o,
    output logic       misaligned_o
);
    always_comb begin
        sel_o = dlen_i == DLEN_B ? 4'b0001 << addr_i :
                dlen_i == DLEN_H ? 4'b0011 << {addr_i[1], 1'b0} : 4'b1111;
        misaligned_o = dlen_i == DLEN_W ? addr_i != 2'b00 :
                       dlen_i == DLEN_H ? addr_i[0] : dlen_i != DLEN_B;
    end
endmodule

// File: rtl/darkriscv_wb_adapter.sv
// darkriscv_wb_adapter: bridges the DarkRISC-V core to a Wishbone bus with a one-entry fetch buffer
module darkriscv_wb_adapter
    import darkriscv_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   iaddr_i,
    output logic [31:0]   idata_o,
    input  logic [31:0]   daddr_i,
    input  logic [31:0]   datao_i,
    output logic [31:0]   datai_o,
    input  logic [2:0]    dlen_i,
    input  logic          drd_i,
    input  logic          dwr_i,
    input  logic          das_i,
    output logic          hlt_o,
    output logic          berr_o,
    darkriscv_wb_if.master wb
);
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, datai_q, datai_d;
    logic [31:0] idata_q, idata_d, itag_q, itag_d, tmo_q, tmo_d;
    logic [3:0]  sel_q, sel_d, dsel;
    logic        we_q, we_d, ivalid_q, ivalid_d, dvalid_q, dvalid_d, berr_q, berr_d;
    logic        busy, dpend, ihit, mis, tmo_exp, done;
    logic [31:0] rdata;

    darkriscv_wb_sel u_sel (.addr_i(daddr_i[1:0]), .dlen_i(dlen_i), .sel_o(dsel), .misaligned_o(mis));

    assign busy    = state_q == DACCESS || state_q == IFETCH;
    assign dpend   = das_i & (drd_i | dwr_i) & ~dvalid_q;
    assign ihit    = ivalid_q & (itag_q == iaddr_i);
    assign hlt_o   = dpend | ~ihit;
    assign tmo_exp = busy & ~wb.ack_i & (tmo_q == 32'(TIMEOUT_CYCLES - 1));
    assign done    = busy & (wb.ack_i | tmo_exp);
    // An aborted access completes like an ack carrying zero.
    assign rdata   = tmo_exp ? 32'h0 : wb.data_i;

    assign wb.cyc_o  = busy;
    assign wb.stb_o  = busy;
    assign wb.we_o   = we_q;
    assign wb.addr_o = addr_q;
    assign wb.data_o = data_q;
    assign wb.sel_o  = sel_q;
    assign datai_o   = datai_q;
    assign idata_o   = idata_q;
    assign berr_o    = berr_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        sel_d    = sel_q;
        we_d     = we_q;
        datai_d  = datai_q;
        idata_d  = idata_q;
        itag_d   = itag_q;
        ivalid_d = ivalid_q;
        berr_d   = 1'b0;
        tmo_d    = busy && !done ? tmo_q + 32'd1 : 32'd0;
        // The core consumes a completed data access on the edge it leaves the stall.
        dvalid_d = dvalid_q & hlt_o;
        unique case (state_q)
            IDLE: begin
                if (dpend && mis) begin
                    berr_d   = 1'b1;
                    dvalid_d = 1'b1;
                    datai_d  = 32'h0;
                    state_d  = GAP;
                end else if (dpend) begin
                    state_d = DACCESS;
                    addr_d  = word_addr(daddr_i);
                    we_d    = dwr_i;
                    data_d  = datao_i;
                    sel_d   = dsel;
                end else if (!ihit) begin
                    state_d = IFETCH;
                    addr_d  = word_addr(iaddr_i);
                    we_d    = 1'b0;
                    sel_d   = 4'hF;
                end
            end
            DACCESS: begin
                if (done) begin
                    state_d  = GAP;
                    dvalid_d = 1'b1;
                    berr_d   = tmo_exp;
                    datai_d  = we_q ? datai_q : rdata;
                end
            end
            IFETCH: begin
                if (done) begin
                    state_d  = GAP;
                    idata_d  = rdata;
                    itag_d   = addr_q;
                    ivalid_d = 1'b1;
                    berr_d   = tmo_exp;
                end
            end
            GAP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            datai_q  <= '0;
            idata_q  <= '0;
            itag_q   <= '0;
            ivalid_q <= 1'b0;
            dvalid_q <= 1'b0;
            berr_q   <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            datai_q  <= datai_d;
            idata_q  <= idata_d;
            itag_q   <= itag_d;
            ivalid_q <= ivalid_d;
            dvalid_q <= dvalid_d;
            berr_q   <= berr_d;
            tmo_q    <= tmo_d;
        end
    end
endmodule

// File: tb/tb_darkriscv_wb_adapter.sv
// tb_darkriscv_wb_adapter: randomized scoreboard bench with a memory-level reference model
module tb_darkriscv_wb_adapter;
    localparam int TMO = 8;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic we; logic [3:0] sel; } txn_t;
    typedef struct { logic [31:0] idata; logic [31:0] datai; bit chk_d; int berrs; } res_t;

    logic clk = 0, rst = 1;
    logic [31:0] iaddr_i = 0, daddr_i = 0, datao_i = 0, idata_o, datai_o;
    logic [2:0]  dlen_i = 0;
    logic        drd_i = 0, dwr_i = 0, das_i = 0, hlt_o, berr_o;

    darkriscv_wb_if wb();

    darkriscv_wb_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .iaddr_i(iaddr_i), .idata_o(idata_o),
        .daddr_i(daddr_i), .datao_i(datao_i), .datai_o(datai_o), .dlen_i(dlen_i),
        .drd_i(drd_i), .dwr_i(dwr_i), .das_i(das_i), .hlt_o(hlt_o), .berr_o(berr_o), .wb(wb)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    txn_t exp_bus[$];
    res_t exp_res[$];
    logic [31:0] slv_mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    int slv_wait = 1;
    bit slv_mute = 0, slv_late = 0;
    int bus_cnt = 0, stb_len = 0, berr_acc = 0, ref_berrs = 0;
    bit rtag_v = 0;
    logic [31:0] rtag = 0, rdata = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endfunction

    // Wishbone slave: acks after slv_wait extra cycles, applies byte-lane writes to its memory.
    initial begin
        int cnt;
        logic [31:0] a, w;
        cnt = 0;
        wb.ack_i = 0;
        wb.data_i = 0;
        forever begin
            @(negedge clk);
            cnt = (wb.cyc_o && wb.stb_o) ? cnt + 1 : 0;
            wb.ack_i = 0;
            if (slv_late) begin
                wb.ack_i = 1;
                wb.data_i = 32'hDEADBEEF;
                slv_late = 0;
            end else if (cnt > slv_wait && !slv_mute) begin
                a = wb.addr_o;
                w = slv_mem.exists(a) ? slv_mem[a] : init_word(a);
                if (wb.we_o) begin
                    for (int b = 0; b < 4; b++) if (wb.sel_o[b]) w[8*b +: 8] = wb.data_o[8*b +: 8];
                    slv_mem[a] = w;
                end
                wb.ack_i = 1;
                wb.data_i = w;
            end
        end
    end

    // Monitor: checks each new bus cycle and each core-visible completion against the queues.
    initial begin
        bit pc;
        txn_t t;
        res_t r;
        pc = 0;
        forever begin
            @(negedge clk);
            if (berr_o) berr_acc++;
            if (wb.cyc_o && !pc) begin
                bus_cnt++;
                stb_len = 0;
                if (exp_bus.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL bus_unexpected: got cycle at %h, required none", wb.addr_o);
                end else begin
                    t = exp_bus.pop_front();
                    chk("bus_addr", wb.addr_o, t.addr);
                    chk("bus_we", 32'(wb.we_o), 32'(t.we));
                    chk("bus_sel", 32'(wb.sel_o), 32'(t.sel));
                    if (t.we) chk("bus_data", wb.data_o, t.data);
                end
            end
            if (wb.stb_o) stb_len++;
            pc = wb.cyc_o;
            if (!rst && !hlt_o && exp_res.size() > 0) begin
                r = exp_res.pop_front();
                chk("idata", idata_o, r.idata);
                if (r.chk_d) chk("datai", datai_o, r.datai);
                chk("berr_count", 32'(berr_acc), 32'(r.berrs));
            end
        end
    end

    // Reference model: one core step (optional data access, then fetch on buffer miss).
    task automatic issue(input logic [31:0] ia, input int op, input logic [31:0] da,
                         input logic [2:0] dl, input logic [31:0] wd);
        txn_t t;
        res_t r;
        bit legal;
        int lane;
        logic [31:0] wa, w;
        lane = int'(da % 4);
        wa = da - da % 4;
        legal = (dl == 3'd1 || dl == 3'd2 || dl == 3'd4);
        if (legal) legal = (da % 32'(dl)) == 0;
        r.chk_d = op == 1 || (op != 0 && !legal);
        r.datai = 0;
        if (op != 0 && !legal) ref_berrs++;
        if (op != 0 && legal) begin
            t.addr = wa;
            t.we = op == 2;
            t.data = wd;
            t.sel = 4'(((1 << dl) - 1) << lane);
            exp_bus.push_back(t);
            w = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
            if (slv_mute) ref_berrs++;
            else if (op == 1) r.datai = w;
            else begin
                for (int b = 0; b < int'(dl); b++) w[8*(lane+b) +: 8] = wd[8*(lane+b) +: 8];
                ref_mem[wa] = w;
            end
        end
        if (!(rtag_v && rtag == ia)) begin
            t.addr = ia;
            t.we = 0;
            t.data = 0;
            t.sel = 4'hF;
            exp_bus.push_back(t);
            rtag_v = 1;
            rtag = ia;
            rdata = slv_mute ? 32'h0 : (ref_mem.exists(ia) ? ref_mem[ia] : init_word(ia));
            if (slv_mute) ref_berrs++;
        end
        r.idata = rdata;
        r.berrs = ref_berrs;
        exp_res.push_back(r);
        iaddr_i = ia;
        daddr_i = da;
        dlen_i = dl;
        datao_i = wd;
        drd_i = op == 1;
        dwr_i = op == 2;
        das_i = op != 0;
    endtask

    task automatic settle();
        for (int n = 0; n < 200 && exp_res.size() > 0; n++) @(posedge clk);
        if (exp_res.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL step_timeout: got hlt_o still high after 200 cycles, required release");
            exp_res.delete();
            exp_bus.delete();
        end
        #1;
    endtask

    initial begin
        txn_t t;
        int n0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hlt", 32'(hlt_o), 1);
        chk("rst_cyc", 32'(wb.cyc_o), 0);
        chk("rst_stb", 32'(wb.stb_o), 0);
        chk("rst_we", 32'(wb.we_o), 0);
        chk("rst_berr", 32'(berr_o), 0);
        chk("rst_addr", wb.addr_o, 0);
        chk("rst_data", wb.data_o, 0);
        chk("rst_sel", 32'(wb.sel_o), 0);
        chk("rst_idata", idata_o, 0);
        chk("rst_datai", datai_o, 0);

        // First fetch after reset with a two-cycle slave.
        slv_wait = 1;
        issue(32'h0, 0, 32'h0, 3'd4, 32'h0);
        rst = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("fetch_lat_hlt", 32'(hlt_o), 0);
        chk("fetch_idata", idata_o, 32'h13);
        settle();

        // Same address held after the fill: buffer hit, no further bus cycle.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_hlt", 32'(hlt_o), 0);
        end
        chk("hold_bus_cnt", 32'(bus_cnt), 1);

        // Byte store at 0x103, then fetch of the next instruction.
        slv_wait = 0;
        issue(32'h4, 2, 32'h103, 3'd1, 32'hAB000000);
        settle();
        chk("sb_bus_cnt", 32'(bus_cnt), 3);

        // Misaligned word load: error pulse, no bus cycle.
        n0 = bus_cnt;
        issue(32'h4, 1, 32'h202, 3'd4, 32'h0);
        settle();
        chk("lw_mis_bus_cnt", 32'(bus_cnt), 32'(n0));
        chk("lw_mis_berr_low", 32'(berr_o), 0);

        // Slave never acks: abort after TMO strobe cycles.
        slv_mute = 1;
        issue(32'h4, 1, 32'h300, 3'd4, 32'h0);
        settle();
        chk("tmo_stb_len", 32'(stb_len), TMO);
        chk("tmo_stb_low", 32'(wb.stb_o), 0);
        slv_mute = 0;

        // Reset during a fetch, with a late ack right after the reset edge.
        slv_wait = 1;
        t.addr = 32'h40;
        t.we = 0;
        t.data = 0;
        t.sel = 4'hF;
        exp_bus.push_back(t);
        iaddr_i = 32'h40;
        das_i = 0;
        drd_i = 0;
        dwr_i = 0;
        @(posedge clk);
        #1;
        chk("pre_rst_cyc", 32'(wb.cyc_o), 1);
        rst = 1;
        @(posedge clk);
        #1;
        chk("mid_rst_cyc", 32'(wb.cyc_o), 0);
        chk("mid_rst_hlt", 32'(hlt_o), 1);
        rst = 0;
        slv_late = 1;
        rtag_v = 0;
        issue(32'h40, 0, 32'h0, 3'd4, 32'h0);
        @(posedge clk);
        #1;
        chk("late_ack_idata", idata_o, 0);
        chk("late_ack_hlt", 32'(hlt_o), 1);
        settle();

        // Randomized core traffic.
        for (int i = 0; i < 300; i++) begin
            int op, k;
            logic [2:0] dl;
            op = $urandom_range(0, 2);
            k = $urandom_range(0, 9);
            dl = k == 0 ? 3'd3 : k == 1 ? 3'd0 : k < 5 ? 3'd1 : k < 8 ? 3'd2 : 3'd4;
            slv_wait = $urandom_range(0, 3);
            issue(32'(4 * $urandom_range(0, 15)), op, 32'(32'h100 + $urandom_range(0, 63)), dl, $urandom);
            settle();
        end

        repeat (3) @(posedge clk);
        chk("bus_queue_empty", 32'(exp_bus.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/darkriscv_wb_adapter.md
DARKRISCV_WB_ADAPTER -- requirements
Module: darkriscv_wb_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, which is the number of unacknowledged bus cycles before an access is aborted.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port iaddr_i, input, 32, core instruction address.
REQ-005 SHALL have port idata_o, output, 32, instruction word to the core.
REQ-006 SHALL have ports daddr_i (input, 32), datao_i (input, 32, lane-aligned write data) and datai_o (output, 32, full read word).
REQ-007 SHALL have ports dlen_i (input, 3, byte count 1/2/4), drd_i, dwr_i and das_i (input, 1 each, read/write/address strobe).
REQ-008 SHALL have ports hlt_o (output, 1, core stall) and berr_o (output, 1, one-cycle bus-error pulse).
REQ-009 SHALL have Wishbone master ports cyc_o, stb_o and we_o (output, 1 each), addr_o (output, 32), data_o (output, 32) and sel_o (output, 4).
REQ-010 SHALL have Wishbone master ports data_i (input, 32) and ack_i (input, 1).

Function
REQ-011 SHALL implement FSM states IDLE, DACCESS, IFETCH and GAP, with at most one bus transaction outstanding.
REQ-012 SHALL hold a one-entry fetch buffer: itag (32), ivalid and idata.
REQ-013 SHALL treat a data request as pending when das_i and (drd_i or dwr_i) are high and dvalid is low.
REQ-014 SHALL drive hlt_o low only when no data request is pending and ivalid and itag==iaddr_i; otherwise hlt_o SHALL be high.
REQ-015 In IDLE, SHALL go to DACCESS when a data request is pending, else to IFETCH on a fetch-buffer miss; a pending data request has priority over a fetch miss.
REQ-016 SHALL assert cyc_o/stb_o on the edge the FSM enters DACCESS or IFETCH, holding addr_o, we_o, data_o and sel_o stable until ack_i is sampled.
REQ-017 SHALL drive addr_o as {address[31:2],2'b00}; SHALL drive we_o = dwr_i in DACCESS and 0 in IFETCH; SHALL pass data_o = datao_i unchanged.
REQ-018 SHALL drive sel_o as: dlen 1 -> 4'b0001<<addr[1:0]; dlen 2 -> 4'b0011<<{addr[1],1'b0}; dlen 4 -> 4'b1111; IFETCH -> 4'b1111.
REQ-019 On ack_i in DACCESS, SHALL deassert cyc_o/stb_o on the same edge, latch datai_o = data_i for reads, set dvalid, and go to GAP.
REQ-020 On ack_i in IFETCH, SHALL deassert cyc_o/stb_o, load idata = data_i, itag = addr, ivalid = 1, and go to GAP.
REQ-021 GAP SHALL last exactly one cycle with cyc_o low and then return to IDLE.
REQ-022 SHALL clear dvalid on the first edge at which hlt_o is low, i.e. when the core advances.
REQ-023 SHALL ignore ack_i in IDLE and GAP.
REQ-024 SHALL count cycles with stb_o high and no ack_i; when the count reaches TIMEOUT_CYCLES, the access SHALL end as if acked with data 0 and berr_o SHALL be high for one cycle.
REQ-025 A misaligned or illegal access (dlen 4 with addr[1:0]!=0; dlen 2 with addr[0]=1; dlen not 1, 2 or 4) SHALL issue no bus cycle, SHALL pulse berr_o, and SHALL set dvalid with datai_o = 0.
REQ-026 SHALL drive idata_o = idata continuously.
REQ-027 Best-case latency SHALL be: fetch miss to hlt_o low = ack cycle + GAP + 1.

Reset
REQ-028 On a rst edge, SHALL set the FSM to IDLE; cyc_o, stb_o, we_o and berr_o to 0; addr_o, data_o, datai_o and idata_o to 0; sel_o to 0; ivalid and dvalid to 0; the timeout counter to 0; hlt_o to 1.
REQ-029 A reset mid-transaction SHALL drop cyc_o/stb_o on that same edge, and a late ack_i SHALL have no effect.

Structure
REQ-030 Package darkriscv_wb_pkg SHALL hold the FSM state enum, the DLEN codes (1, 2, 4) and the default TIMEOUT constant.
REQ-031 Sub-module darkriscv_wb_sel SHALL be purely combinational, taking address[1:0] and dlen and producing sel and misaligned.

Verification
REQ-032 SHALL verify: reset, then iaddr_i=0x0 with the slave acking in 2 cycles, data 0x00000013 -> one read cycle with sel_o=4'hF and addr_o=0x0; idata_o=0x13 and hlt_o low 4 cycles after reset release.
REQ-033 SHALL verify: sb with daddr_i=0x103, dlen_i=1, datao_i=0xAB000000 -> we_o=1, sel_o=4'b1000, addr_o=0x100, data_o=0xAB000000, with the data cycle preceding any fetch.
REQ-034 SHALL verify: lw at 0x202 -> no cyc_o assertion, berr_o high for exactly one cycle, datai_o=0.
REQ-035 SHALL verify: a slave that never acks, TIMEOUT_CYCLES=8 -> stb_o high for 8 cycles, then low, with a one-cycle berr_o pulse.
REQ-036 SHALL verify: rst asserted during an IFETCH with the ack arriving 1 cycle later -> cyc_o low after the reset edge, ivalid=0, hlt_o=1, ack ignored.
REQ-037 SHALL verify: the same iaddr_i held over 3 cycles after a fill -> exactly one bus cycle and hlt_o low throughout.
